// File: rtl/line_rasterizer.sv
// line_rasterizer
//   Walks one projected edge with integer Bresenham and emits one pixel write
//   per cycle towards the framebuffer adapter. Endpoints arrive origin-centred
//   with +y up; they are converted to screen space (origin top-left, +y down)
//   before the walk.
//
// Ports
//   clock, resetn         rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   edge request handshake (accepted only in IDLE)
//   x0,y0,x1,y1           signed endpoints, projection space
//   colour                edge colour
//   plot / plot_ready     pixel write handshake
//   px, py, pcolour       pixel position (screen space) and colour
//   busy                  edge in progress (SETUP or DRAW)
//   line_done             one-cycle pulse after the last pixel step
//
// Build option
//   CLIP_EN  when defined, off-screen points are suppressed (plot=0) and the
//            walk steps through them without waiting for plot_ready.
//            When undefined, every point is plotted and px/py wrap.

module line_rasterizer #(
  parameter int COORD_W = 12,
  parameter int SCR_W   = 320,
  parameter int SCR_H   = 240,
  parameter int XW      = 9,
  parameter int YW      = 8,
  parameter int CW      = 3
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COORD_W-1:0] x0,
  input  logic signed [COORD_W-1:0] y0,
  input  logic signed [COORD_W-1:0] x1,
  input  logic signed [COORD_W-1:0] y1,
  input  logic        [CW-1:0]      colour,
  output logic                      plot,
  input  logic                      plot_ready,
  output logic        [XW-1:0]      px,
  output logic        [YW-1:0]      py,
  output logic        [CW-1:0]      pcolour,
  output logic                      busy,
  output logic                      line_done
);

  localparam int IW = COORD_W + 2;

  localparam logic signed [IW-1:0] HALF_W = IW'(SCR_W / 2);
  localparam logic signed [IW-1:0] HALF_H = IW'(SCR_H / 2);
  localparam logic signed [IW-1:0] ONE    = IW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Captured request
  logic signed [COORD_W-1:0] rx0, ry0, rx1, ry1;

  // Walk state
  logic signed [IW-1:0] cx, cy, ex, ey, dx, dy, err;
  logic                 sxn, syn;   // step direction is negative

  // Setup arithmetic
  logic signed [IW-1:0] s_x0, s_y0, s_x1, s_y1, d_x, d_y, a_dx, a_dy;

  // Step arithmetic
  logic signed [IW:0]   e2, ndy_w, dx_w;
  logic                 stx, sty, last, advance;
  logic signed [IW-1:0] err_n, cx_n, cy_n;

  function automatic logic signed [IW-1:0] ext(input logic signed [COORD_W-1:0] v);
    return {{2{v[COORD_W-1]}}, v};
  endfunction

`ifdef CLIP_EN
  localparam logic signed [IW-1:0] LIM_W = IW'(SCR_W);
  localparam logic signed [IW-1:0] LIM_H = IW'(SCR_H);

  function automatic logic vis(input logic signed [IW-1:0] x,
                               input logic signed [IW-1:0] y);
    return !x[IW-1] && (x < LIM_W) && !y[IW-1] && (y < LIM_H);
  endfunction
`else
  function automatic logic vis(input logic signed [IW-1:0] x,
                               input logic signed [IW-1:0] y);
    return (x == x) && (y == y);
  endfunction
`endif

  // Projection -> screen conversion and deltas for the captured edge
  always_comb begin
    s_x0 = ext(rx0) + HALF_W;
    s_y0 = HALF_H - ext(ry0);
    s_x1 = ext(rx1) + HALF_W;
    s_y1 = HALF_H - ext(ry1);
    d_x  = s_x1 - s_x0;
    d_y  = s_y1 - s_y0;
    a_dx = d_x[IW-1] ? -d_x : d_x;
    a_dy = d_y[IW-1] ? -d_y : d_y;
  end

  // One Bresenham step from the current point. e2 is widened by one bit so
  // doubling err cannot wrap.
  always_comb begin
    e2      = {err, 1'b0};
    ndy_w   = -{dy[IW-1], dy};
    dx_w    = {dx[IW-1], dx};
    stx     = (e2 > ndy_w);
    sty     = (e2 < dx_w);
    err_n   = err - (stx ? dy : '0) + (sty ? dx : '0);
    cx_n    = stx ? (sxn ? cx - ONE : cx + ONE) : cx;
    cy_n    = sty ? (syn ? cy - ONE : cy + ONE) : cy;
    last    = (cx == ex) && (cy == ey);
    // A suppressed point (plot=0 while drawing) steps without a handshake.
    advance = plot_ready || !plot;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SETUP;
      SETUP:   state_nxt = DRAW;
      DRAW:    if (advance && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rx0     <= '0;
      ry0     <= '0;
      rx1     <= '0;
      ry1     <= '0;
      pcolour <= '0;
      cx      <= '0;
      cy      <= '0;
      ex      <= '0;
      ey      <= '0;
      dx      <= '0;
      dy      <= '0;
      err     <= '0;
      sxn     <= 1'b0;
      syn     <= 1'b0;
      plot    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          plot <= 1'b0;
          if (in_valid) begin
            rx0     <= x0;
            ry0     <= y0;
            rx1     <= x1;
            ry1     <= y1;
            pcolour <= colour;
          end
        end
        SETUP: begin
          cx   <= s_x0;
          cy   <= s_y0;
          ex   <= s_x1;
          ey   <= s_y1;
          dx   <= a_dx;
          dy   <= a_dy;
          err  <= a_dx - a_dy;
          sxn  <= d_x[IW-1];
          syn  <= d_y[IW-1];
          plot <= vis(s_x0, s_y0);
        end
        DRAW: begin
          if (advance) begin
            if (last) begin
              plot <= 1'b0;
            end else begin
              cx   <= cx_n;
              cy   <= cy_n;
              err  <= err_n;
              plot <= vis(cx_n, cy_n);
            end
          end
        end
        default: plot <= 1'b0;
      endcase
    end
  end

  assign px        = cx[XW-1:0];
  assign py        = cy[YW-1:0];
  assign in_ready  = (state == IDLE);
  assign busy      = (state == SETUP) || (state == DRAW);
  assign line_done = (state == DONE);

endmodule

// File: tb/tb_line_rasterizer.sv
module tb_line_rasterizer;

  logic               clock = 1'b0;
  logic               resetn = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [11:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic        [2:0]  colour = '0;
  logic               plot;
  logic               plot_ready = 1'b1;
  logic        [8:0]  px;
  logic        [7:0]  py;
  logic        [2:0]  pcolour;
  logic               busy;
  logic               line_done;

  line_rasterizer #(
    .COORD_W(12), .SCR_W(320), .SCR_H(240), .XW(9), .YW(8), .CW(3)
  ) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .colour(colour),
    .plot(plot), .plot_ready(plot_ready),
    .px(px), .py(py), .pcolour(pcolour),
    .busy(busy), .line_done(line_done)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [19:0] expq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void push(input int x, input int y, input int c);
    logic [19:0] v;
    v[19:11] = 9'(x);
    v[10:3]  = 8'(y);
    v[2:0]   = 3'(c);
    expq.push_back(v);
  endfunction

  // Scoreboard: every accepted pixel must match the next expected one
  always @(negedge clock) begin
    if (resetn && plot && plot_ready) begin
      total++;
      assert (expq.size() != 0) else begin
        bad++;
        $error("FAIL extra_plot observed=%0d expected=none", {px, py, pcolour});
      end
      if (expq.size() != 0) chk("pixel", {12'd0, px, py, pcolour}, {12'd0, expq.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Called at a negedge; returns just after the accepting posedge.
  task automatic send(input int ax0, input int ay0, input int ax1, input int ay1, input int col);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clock); n++; end
    chk("ready_before_send", {31'd0, in_ready}, 32'd1);
    x0 = 12'(ax0); y0 = 12'(ay0); x1 = 12'(ax1); y1 = 12'(ay1);
    colour = 3'(col);
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    // Garbage on the inputs must be ignored while the edge is in progress
    x0 = 12'h5a5; y0 = 12'h3c3; x1 = 12'h7ff; y1 = 12'h800; colour = ~colour;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int steps);
    int n;
    n = 0;
    while (!line_done && n < 300) begin @(negedge clock); n++; end
    chk({tag, "_steps"}, n, steps);
    chk({tag, "_done_plot"}, {31'd0, plot}, 32'd0);
    chk({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_queue_empty"}, expq.size(), 32'd0);
    @(negedge clock);
    chk({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_done_pulse"}, {31'd0, line_done}, 32'd0);
  endtask

  // Full edge with latency checks: SETUP at the first negedge, first point
  // presented at the second.
  task automatic do_edge(input int ax0, input int ay0, input int ax1, input int ay1,
                         input int col, input int steps, input logic first_plot, input string tag);
    send(ax0, ay0, ax1, ay1, col);
    chk({tag, "_setup_plot"}, {31'd0, plot}, 32'd0);
    chk({tag, "_setup_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_setup_ready"}, {31'd0, in_ready}, 32'd0);
    @(negedge clock);
    chk({tag, "_first_plot"}, {31'd0, plot}, {31'd0, first_plot});
    chk({tag, "_draw_busy"}, {31'd0, busy}, 32'd1);
    wait_done(tag, steps);
  endtask

  initial begin
    int n;
    // Reset state
    #12;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_plot", {31'd0, plot}, 32'd0);
    chk("rst_px", {23'd0, px}, 32'd0);
    chk("rst_py", {24'd0, py}, 32'd0);
    chk("rst_pcolour", {29'd0, pcolour}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, line_done}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // 1: horizontal
    for (int i = 0; i < 4; i++) push(160 + i, 120, 5);
    do_edge(0, 0, 3, 0, 5, 4, 1'b1, "t1");

    // 2: zero length
    push(160, 120, 2);
    do_edge(0, 0, 0, 0, 2, 1, 1'b1, "t2");

    // 3: steep
    push(160, 120, 7); push(160, 119, 7); push(161, 118, 7); push(161, 117, 7);
    do_edge(0, 0, 1, 3, 7, 4, 1'b1, "t3");

    // 4: backpressure on the second pixel
    for (int i = 0; i < 4; i++) push(160 + i, 120, 5);
    send(0, 0, 3, 0, 5);
    n = 0;
    while (!(plot && px == 9'd161) && n < 20) begin @(posedge clock); #1; n++; end
    chk("t4_reach_161", {31'd0, plot && px == 9'd161}, 32'd1);
    plot_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t4_hold_px", {23'd0, px}, 32'd161);
      chk("t4_hold_py", {24'd0, py}, 32'd120);
      chk("t4_hold_plot", {31'd0, plot}, 32'd1);
    end
    @(posedge clock); #1;
    plot_ready = 1'b1;
    @(negedge clock);
    chk("t4_hold_px4", {23'd0, px}, 32'd161);
    wait_done("t4", 3);

    // 5: edge crossing the left border
`ifdef CLIP_EN
    for (int i = 0; i <= 5; i++) push(i, 120, 3);
    do_edge(-170, 0, -155, 0, 3, 16, 1'b0, "t5clip");
`else
    for (int i = -10; i <= 5; i++) push(i & 511, 120, 3);
    do_edge(-170, 0, -155, 0, 3, 16, 1'b1, "t5wrap");
`endif

    // 6: reset during the second pixel
    push(160, 120, 5);
    send(0, 0, 3, 0, 5);
    n = 0;
    while (!(plot && px == 9'd161) && n < 20) begin @(posedge clock); #1; n++; end
    chk("t6_reach_161", {31'd0, plot && px == 9'd161}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("t6_plot", {31'd0, plot}, 32'd0);
    chk("t6_px", {23'd0, px}, 32'd0);
    chk("t6_py", {24'd0, py}, 32'd0);
    chk("t6_pcolour", {29'd0, pcolour}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (5) begin
      @(negedge clock);
      chk("t6_no_resume", {30'd0, plot, busy}, 32'd0);
    end
    chk("t6_ready_after", {31'd0, in_ready}, 32'd1);
    chk("t6_queue_empty", expq.size(), 32'd0);

    // Recovery after the abort
    push(160, 120, 6);
    do_edge(0, 0, 0, 0, 6, 1, 1'b1, "t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
